// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester Alu arbiter: widths, opcode codes
// and the controller state encodings.
package alu_arbiter_pkg;

   localparam int WIDTH = 32;
   localparam int OPW   = 6;

   typedef enum logic [OPW-1:0] {
      OP_ADD = 6'd0,
      OP_SUB = 6'd1,
      OP_AND = 6'd2,
      OP_OR  = 6'd3,
      OP_SLT = 6'd4
   } alu_op_e;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   // Every code above SLT is outside the Alu's repertoire.
   function automatic logic is_legal_op(input logic [OPW-1:0] op);
      return op <= OP_SLT;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response handshakes of both requesters plus the Alu-side bus.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface alu_arbiter_if;
   import alu_arbiter_pkg::*;

   logic [1:0]       reqValid;
   logic [1:0]       reqReady;
   logic [OPW-1:0]   reqOpCode0;
   logic [OPW-1:0]   reqOpCode1;
   logic [WIDTH-1:0] reqA0;
   logic [WIDTH-1:0] reqA1;
   logic [WIDTH-1:0] reqB0;
   logic [WIDTH-1:0] reqB1;
   logic [1:0]       respValid;
   logic [1:0]       respReady;
   logic [WIDTH-1:0] respResult;
   logic             respErr;
   logic [WIDTH-1:0] aluOperand1;
   logic [WIDTH-1:0] aluOperand2;
   logic [OPW-1:0]   aluOpCode;
   logic [WIDTH-1:0] aluResult;

   modport slave (
      input  reqValid, reqOpCode0, reqOpCode1, reqA0, reqA1, reqB0, reqB1,
      input  respReady, aluResult,
      output reqReady, respValid, respResult, respErr,
      output aluOperand1, aluOperand2, aluOpCode
   );

   modport master (
      output reqValid, reqOpCode0, reqOpCode1, reqA0, reqA1, reqB0, reqB1,
      output respReady, aluResult,
      input  reqReady, respValid, respResult, respErr,
      input  aluOperand1, aluOperand2, aluOpCode
   );

endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin grant: a contested cycle goes to the
// requester that did not win last time.
module rr_arbiter2 (
   input  logic [1:0] req_valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_grant
         assign grant[gi] = req_valid[gi] &
                            (~req_valid[1-gi] | (last_grant != 1'(gi)));
      end
   endgenerate

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational Alu between two requesters: accept, execute from
// registered operands for one cycle, then hold the response until consumed.
module alu_arbiter (
   input  logic          clk,
   input  logic          rst_n,
   alu_arbiter_if.slave  bus
);
   import alu_arbiter_pkg::*;

   logic [1:0]       state_reg;
   logic             owner_reg;
   logic             last_grant_reg;
   logic [WIDTH-1:0] op1_reg;
   logic [WIDTH-1:0] op2_reg;
   logic [OPW-1:0]   opc_reg;
   logic [WIDTH-1:0] result_reg;
   logic             err_reg;
   logic [1:0]       grant;
   logic             accept;

   rr_arbiter2 u_rr (
      .req_valid  (bus.reqValid),
      .last_grant (last_grant_reg),
      .grant      (grant)
   );

   // Grant only reaches the requesters while idle; never both bits.
   assign bus.reqReady    = (state_reg == IDLE) ? grant : 2'b00;
   assign accept          = |bus.reqReady;
   assign bus.respValid   = (state_reg == RESP) ? {owner_reg, ~owner_reg} : 2'b00;
   assign bus.respResult  = result_reg;
   assign bus.respErr     = err_reg;
   assign bus.aluOperand1 = op1_reg;
   assign bus.aluOperand2 = op2_reg;
   assign bus.aluOpCode   = opc_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         owner_reg      <= 1'b0;
         last_grant_reg <= 1'b1;
         op1_reg        <= '0;
         op2_reg        <= '0;
         opc_reg        <= '0;
         result_reg     <= '0;
         err_reg        <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  owner_reg <= grant[1];
                  op1_reg   <= grant[1] ? bus.reqA1      : bus.reqA0;
                  op2_reg   <= grant[1] ? bus.reqB1      : bus.reqB0;
                  opc_reg   <= grant[1] ? bus.reqOpCode1 : bus.reqOpCode0;
                  state_reg <= EXEC;
               end
            end
            EXEC: begin
               // Whatever the Alu produces for an unknown code is discarded.
               result_reg <= is_legal_op(opc_reg) ? bus.aluResult : '0;
               err_reg    <= ~is_legal_op(opc_reg);
               state_reg  <= RESP;
            end
            RESP: begin
               if (bus.respReady[owner_reg]) begin
                  last_grant_reg <= owner_reg;
                  state_reg      <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural Alu attached to the bus.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   alu_arbiter_if bus ();

   alu_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Behavioural Alu; unknown codes yield a nonzero pattern on purpose.
   always_comb begin
      case (bus.aluOpCode)
         6'd0:    bus.aluResult = bus.aluOperand1 + bus.aluOperand2;
         6'd1:    bus.aluResult = bus.aluOperand1 - bus.aluOperand2;
         6'd2:    bus.aluResult = bus.aluOperand1 & bus.aluOperand2;
         6'd3:    bus.aluResult = bus.aluOperand1 | bus.aluOperand2;
         6'd4:    bus.aluResult = ($signed(bus.aluOperand1) < $signed(bus.aluOperand2)) ? 32'd1 : 32'd0;
         default: bus.aluResult = bus.aluOperand1 ^ bus.aluOperand2 ^ 32'hA5A5_0000;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input int r, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      if (r == 0) begin
         bus.reqOpCode0 = op;
         bus.reqA0      = a;
         bus.reqB0      = b;
      end else begin
         bus.reqOpCode1 = op;
         bus.reqA1      = a;
         bus.reqB1      = b;
      end
   endtask

   initial begin
      bus.reqValid  = 2'b00;
      bus.respReady = 2'b00;
      drive_req(0, 6'd0, 32'd0, 32'd0);
      drive_req(1, 6'd0, 32'd0, 32'd0);

      // Reset state
      #1;
      check("rst_reqReady",   32'(bus.reqReady),    32'd0);
      check("rst_respValid",  32'(bus.respValid),   32'd0);
      check("rst_respResult", bus.respResult,       32'd0);
      check("rst_respErr",    32'(bus.respErr),     32'd0);
      check("rst_aluOp1",     bus.aluOperand1,      32'd0);
      check("rst_aluOpCode",  32'(bus.aluOpCode),   32'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // 1. Req0 alone: ADD 2,3
      drive_req(0, 6'd0, 32'd2, 32'd3);
      bus.reqValid = 2'b01;
      #1;
      check("t1_reqReady", 32'(bus.reqReady), 32'h1);
      tick();
      bus.reqValid = 2'b00;
      drive_req(0, 6'd1, 32'd99, 32'd99);
      check("t1_exec_reqReady",  32'(bus.reqReady),  32'h0);
      check("t1_exec_respValid", 32'(bus.respValid), 32'h0);
      check("t1_aluOp1",         bus.aluOperand1,    32'd2);
      check("t1_aluOp2",         bus.aluOperand2,    32'd3);
      check("t1_aluOpCode",      32'(bus.aluOpCode), 32'd0);
      tick();
      check("t1_respValid", 32'(bus.respValid), 32'h1);
      check("t1_result",    bus.respResult,     32'd5);
      check("t1_err",       32'(bus.respErr),   32'd0);
      bus.respReady = 2'b01;
      tick();
      bus.respReady = 2'b00;
      check("t1_done_respValid", 32'(bus.respValid), 32'h0);

      // 2. Fresh reset, simultaneous requests: req0 first, then req1
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      drive_req(0, 6'd1, 32'd5, 32'd5);
      drive_req(1, 6'd4, 32'd2, 32'd3);
      bus.reqValid = 2'b11;
      #1;
      check("t2_first_grant", 32'(bus.reqReady), 32'h1);
      tick();
      bus.reqValid = 2'b10;
      tick();
      check("t2_resp0_valid",  32'(bus.respValid), 32'h1);
      check("t2_resp0_result", bus.respResult,     32'd0);
      check("t2_resp_reqReady", 32'(bus.reqReady), 32'h0);
      bus.respReady = 2'b01;
      tick();
      bus.respReady = 2'b00;
      check("t2_second_grant", 32'(bus.reqReady), 32'h2);
      tick();
      bus.reqValid = 2'b00;
      tick();
      check("t2_resp1_valid",  32'(bus.respValid), 32'h2);
      check("t2_resp1_result", bus.respResult,     32'd1);
      bus.respReady = 2'b10;
      tick();
      bus.respReady = 2'b00;

      // 3. Both requesters saturating: grants alternate, one op per 3 cycles
      bus.reqValid  = 2'b11;
      bus.respReady = 2'b11;
      for (int k = 0; k < 6; k++) begin
         logic [1:0]  exp_g;
         logic [31:0] exp_r;
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_r = (k % 2 == 0) ? 32'(10 + k) : 32'(100 - k);
         drive_req(0, 6'd0, 32'd10,  32'(k));
         drive_req(1, 6'd1, 32'd100, 32'(k));
         #1;
         check($sformatf("t3_grant%0d", k), 32'(bus.reqReady), 32'(exp_g));
         tick();
         tick();
         check($sformatf("t3_valid%0d", k),  32'(bus.respValid), 32'(exp_g));
         check($sformatf("t3_result%0d", k), bus.respResult,     exp_r);
         tick();
      end
      bus.reqValid  = 2'b00;
      bus.respReady = 2'b00;

      // 4. Backpressure on req1 while req0 waits
      drive_req(1, 6'd3, 32'h0F0, 32'h00F);
      bus.reqValid = 2'b10;
      #1;
      check("t4_grant1", 32'(bus.reqReady), 32'h2);
      tick();
      drive_req(0, 6'd0, 32'd1, 32'd1);
      bus.reqValid  = 2'b11;
      bus.respReady = 2'b01;
      tick();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t4_hold_valid%0d", i),  32'(bus.respValid), 32'h2);
         check($sformatf("t4_hold_result%0d", i), bus.respResult,     32'h0FF);
         check($sformatf("t4_hold_ready%0d", i),  32'(bus.reqReady),  32'h0);
         tick();
      end
      bus.respReady = 2'b10;
      tick();
      bus.respReady = 2'b00;
      check("t4_req0_grant", 32'(bus.reqReady), 32'h1);
      tick();
      bus.reqValid = 2'b00;
      tick();
      check("t4_req0_valid",  32'(bus.respValid), 32'h1);
      check("t4_req0_result", bus.respResult,     32'd2);
      bus.respReady = 2'b01;
      tick();
      bus.respReady = 2'b00;

      // 5. Illegal opcode, then a signed compare
      drive_req(0, 6'h3F, 32'd7, 32'd8);
      bus.reqValid = 2'b01;
      tick();
      bus.reqValid = 2'b00;
      tick();
      check("t5_ill_valid",  32'(bus.respValid), 32'h1);
      check("t5_ill_err",    32'(bus.respErr),   32'd1);
      check("t5_ill_result", bus.respResult,     32'd0);
      bus.respReady = 2'b01;
      tick();
      bus.respReady = 2'b00;
      drive_req(0, 6'd4, 32'hFFFF_FFFD, 32'd3);
      bus.reqValid = 2'b01;
      tick();
      bus.reqValid = 2'b00;
      tick();
      check("t5_slt_result", bus.respResult,   32'd1);
      check("t5_slt_err",    32'(bus.respErr), 32'd0);
      bus.respReady = 2'b01;
      tick();
      bus.respReady = 2'b00;

      // 6. Reset during EXEC of req1 aborts the operation
      drive_req(1, 6'd2, 32'hFF, 32'h0F);
      bus.reqValid = 2'b10;
      #1;
      check("t6_grant1", 32'(bus.reqReady), 32'h2);
      tick();
      bus.reqValid = 2'b00;
      check("t6_exec_opcode", 32'(bus.aluOpCode), 32'd2);
      check("t6_exec_op1",    bus.aluOperand1,    32'hFF);
      rst_n = 1'b0;
      #1;
      check("t6_rst_respValid", 32'(bus.respValid), 32'h0);
      check("t6_rst_reqReady",  32'(bus.reqReady),  32'h0);
      check("t6_rst_aluOp1",    bus.aluOperand1,    32'd0);
      check("t6_rst_aluOpCode", 32'(bus.aluOpCode), 32'd0);
      #1;
      rst_n = 1'b1;
      tick();
      tick();
      check("t6_no_resp",   32'(bus.respValid), 32'h0);
      check("t6_no_result", bus.respResult,     32'd0);
      bus.reqValid = 2'b11;
      #1;
      check("t6_grant_after_rst", 32'(bus.reqReady), 32'h1);
      bus.reqValid = 2'b00;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
